fft_stage_ctrl: RTL and testbench
=================================

FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

Interface
REQ-001 The block SHALL have parameter LOG2N, default 10: log2 of FFT length N; legal range 3..16.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 18: read address width; must be >= LOG2N.
REQ-003 The block SHALL have parameter PIPE_LAT, default 6: drain cycles between stages, covering the switch, butterfly and write-back latency; legal range 1..63.
REQ-004 The block SHALL have port clk, input, 1: clock; all logic on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1: single-cycle request to run one full N-point transform.
REQ-007 The block SHALL have port abort, input, 1: synchronous cancel of the current transform.
REQ-008 The block SHALL have port busy, output, 1: high from start acceptance until the done cycle inclusive.
REQ-009 The block SHALL have port done, output, 1: one-cycle pulse when the last stage has drained.
REQ-010 The block SHALL have port stage, output, 5: current stage index, 0..LOG2N-1.
REQ-011 The block SHALL have port first_level, output, 1: high while stage==0 and busy.
REQ-012 The block SHALL have port rd_valid, output, 1: read-request strobe, one butterfly per cycle.
REQ-013 The block SHALL have port rd_addr_a, output, ADDR_WIDTH: butterfly upper-leg address.
REQ-014 The block SHALL have port rd_addr_b, output, ADDR_WIDTH: butterfly lower-leg address.
REQ-015 The block SHALL have port tw_addr, output, LOG2N-1: twiddle ROM index.

Function
REQ-016 The FSM SHALL have states IDLE, READ, DRAIN and DONE.
REQ-017 IDLE -> READ SHALL occur on start=1; start SHALL be ignored in any other state.
REQ-018 READ SHALL issue N/2 consecutive cycles with rd_valid=1, butterfly counter k = 0..N/2-1.
REQ-019 Address rule: span=2^stage, pos=k mod span; rd_addr_a = (k>>stage)*2*span + pos; rd_addr_b = rd_addr_a + span; both zero-extended to ADDR_WIDTH.
REQ-020 Twiddle rule: tw_addr = pos << (LOG2N-1-stage).
REQ-021 All outputs SHALL be registered; rd_valid and its addresses SHALL be asserted on the same cycle.
REQ-022 READ -> DRAIN SHALL occur after k = N/2-1 is issued; DRAIN SHALL last exactly PIPE_LAT cycles with rd_valid=0.
REQ-023 DRAIN exit SHALL go to READ with stage+1 and k=0 if stage < LOG2N-1, otherwise to DONE.
REQ-024 DONE SHALL last one cycle with done=1 and busy=1, then return to IDLE with stage=0.
REQ-025 A transform SHALL take exactly 1 + LOG2N*(N/2+PIPE_LAT) cycles from the start cycle to the done cycle.
REQ-026 abort=1 in any non-IDLE state SHALL return to IDLE on the next edge: rd_valid=0, busy=0, no done pulse, counters cleared; abort has priority over start and all transitions.
REQ-027 Simultaneous start and abort in IDLE SHALL leave the block in IDLE.

Reset
REQ-028 Reset SHALL put the FSM in IDLE and set busy=0, done=0, stage=0, first_level=0, rd_valid=0, rd_addr_a=0, rd_addr_b=0, tw_addr=0.
REQ-029 Reset asserted mid-transform SHALL discard all progress; no done pulse SHALL follow.

Configuration
REQ-030 With FFT_STAGE_CTRL_STALL_EN defined, the block SHALL have an input port stall (1 bit); stall=1 in READ forces rd_valid=0 and holds k, stage and the addresses; stall=1 in DRAIN holds the drain counter; stall SHALL have no effect in IDLE or DONE.
REQ-031 Without FFT_STAGE_CTRL_STALL_EN, the stall port SHALL be absent and the timing SHALL be exactly as in REQ-025.

Verification
REQ-032 LOG2N=3, PIPE_LAT=2, start pulse -> stage 0 pairs (0,1),(2,3),(4,5),(6,7), all tw=0, first_level=1; done at cycle 1+3*(4+2)=19.
REQ-033 Same config, stage 1 -> pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2; stage 2 -> pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3.
REQ-034 start re-pulsed at cycle 5 while busy -> ignored; exactly one done pulse at cycle 19.
REQ-035 abort at the second READ cycle of stage 1 -> rd_valid=0 and busy=0 on the next cycle; no done; a new start then runs a full 19-cycle transform.
REQ-036 rst_n low during DRAIN of stage 0 -> all outputs 0 immediately; no done after release.
REQ-037 With FFT_STAGE_CTRL_STALL_EN, stall high for 3 cycles at k=2 of stage 0 -> same address sequence, done delayed by exactly 3 cycles, at cycle 22.

Source files
------------

// File: rtl/fft_stage_ctrl_if.sv
// Control/address bundle between an FFT stage sequencer and its butterfly datapath.
interface fft_stage_ctrl_if #(
    parameter int LOG2N      = 10,
    parameter int ADDR_WIDTH = 18
);
    logic                  start;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic [4:0]            stage;
    logic                  first_level;
    logic                  rd_valid;
    logic [ADDR_WIDTH-1:0] rd_addr_a;
    logic [ADDR_WIDTH-1:0] rd_addr_b;
    logic [LOG2N-2:0]      tw_addr;

    modport master (
        output start, abort,
        input  busy, done, stage, first_level, rd_valid, rd_addr_a, rd_addr_b, tw_addr
    );

    modport slave (
        input  start, abort,
        output busy, done, stage, first_level, rd_valid, rd_addr_a, rd_addr_b, tw_addr
    );
endinterface

// File: rtl/fft_stage_ctrl.sv
// Radix-2 in-place FFT stage sequencer: butterfly read addresses, twiddle index and stage drain timing.
// Optional stall input is enabled by defining FFT_STAGE_CTRL_STALL_EN.
module fft_stage_ctrl #(
    parameter int LOG2N      = 10,
    parameter int ADDR_WIDTH = 18,
    parameter int PIPE_LAT   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef FFT_STAGE_CTRL_STALL_EN
    input  logic             stall,
`endif
    fft_stage_ctrl_if.slave  bus
);
    localparam int KW = LOG2N - 1;
    localparam logic [KW-1:0]    K_LAST     = '1;
    localparam logic [KW-1:0]    K_ONE      = KW'(1);
    localparam logic [LOG2N-1:0] ONE_N      = LOG2N'(1);
    localparam logic [4:0]       STAGE_LAST = 5'(LOG2N - 1);
    localparam logic [5:0]       DRAIN_LAST = 6'(PIPE_LAT - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [4:0]            stage_q, stage_d;
    logic [5:0]            drain_q, drain_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  first_level_q, first_level_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [ADDR_WIDTH-1:0] rd_addr_a_q, rd_addr_a_d;
    logic [ADDR_WIDTH-1:0] rd_addr_b_q, rd_addr_b_d;
    logic [KW-1:0]         tw_addr_q, tw_addr_d;
    logic                  stall_w;
    logic                  stalled_read;

`ifdef FFT_STAGE_CTRL_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    function automatic logic [LOG2N-1:0] pos_of(input logic [KW-1:0] k, input logic [4:0] st);
        logic [LOG2N-1:0] kx;
        kx = {1'b0, k};
        return kx & ((ONE_N << st) - ONE_N);
    endfunction

    // Upper leg: butterfly group base (k>>stage)*2*span plus offset within the group.
    function automatic logic [LOG2N-1:0] leg_a(input logic [KW-1:0] k, input logic [4:0] st);
        logic [LOG2N-1:0] kx;
        kx = {1'b0, k};
        return ((kx >> st) << (st + 5'd1)) | pos_of(k, st);
    endfunction

    function automatic logic [KW-1:0] twiddle(input logic [KW-1:0] k, input logic [4:0] st);
        logic [LOG2N-1:0] t;
        t = pos_of(k, st) << (STAGE_LAST - st);
        return t[KW-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        drain_d = drain_q;
        stalled_read = (state_q == READ) && stall_w;

        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
            k_d     = '0;
            stage_d = '0;
            drain_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_d = READ;
                        k_d     = '0;
                        stage_d = '0;
                    end
                end
                READ: begin
                    if (!stall_w) begin
                        if (k_q == K_LAST) begin
                            state_d = DRAIN;
                            drain_d = '0;
                        end else begin
                            k_d = k_q + K_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (!stall_w) begin
                        if (drain_q == DRAIN_LAST) begin
                            if (stage_q == STAGE_LAST) begin
                                state_d = DONE;
                            end else begin
                                state_d = READ;
                                stage_d = stage_q + 5'd1;
                                k_d     = '0;
                            end
                        end else begin
                            drain_d = drain_q + 6'd1;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    k_d     = '0;
                    stage_d = '0;
                    drain_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs are derived from the next state so every port is a flop.
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE);
        first_level_d = busy_d && (stage_d == 5'd0);
        rd_valid_d    = (state_d == READ) && !stalled_read;
        rd_addr_a_d   = '0;
        rd_addr_b_d   = '0;
        tw_addr_d     = '0;
        if (state_d == READ) begin
            rd_addr_a_d = ADDR_WIDTH'(leg_a(k_d, stage_d));
            rd_addr_b_d = ADDR_WIDTH'(leg_a(k_d, stage_d) + (ONE_N << stage_d));
            tw_addr_d   = twiddle(k_d, stage_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            k_q           <= '0;
            stage_q       <= '0;
            drain_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            first_level_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_addr_a_q   <= '0;
            rd_addr_b_q   <= '0;
            tw_addr_q     <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            stage_q       <= stage_d;
            drain_q       <= drain_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            first_level_q <= first_level_d;
            rd_valid_q    <= rd_valid_d;
            rd_addr_a_q   <= rd_addr_a_d;
            rd_addr_b_q   <= rd_addr_b_d;
            tw_addr_q     <= tw_addr_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.stage       = stage_q;
    assign bus.first_level = first_level_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_addr_a   = rd_addr_a_q;
    assign bus.rd_addr_b   = rd_addr_b_q;
    assign bus.tw_addr     = tw_addr_q;
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl (N=8, PIPE_LAT=2): timeline model checked every cycle plus literal address tables.
`timescale 1ns/1ps
module tb_fft_stage_ctrl;
    localparam int LOG2N = 3;
    localparam int AW    = 8;
    localparam int PL    = 2;
    localparam int HALF  = (1 << LOG2N) / 2;
    localparam int PER   = HALF + PL;
    localparam int TOTAL = 1 + LOG2N * PER;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0;
    always #5 clk = ~clk;

    fft_stage_ctrl_if #(.LOG2N(LOG2N), .ADDR_WIDTH(AW)) bus ();

    fft_stage_ctrl #(.LOG2N(LOG2N), .ADDR_WIDTH(AW), .PIPE_LAT(PL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef FFT_STAGE_CTRL_STALL_EN
        .stall (stall),
`endif
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position on the transform timeline (1..TOTAL), frozen while stalled.
    bit m_active = 0;
    int m_t      = 0;
    bit m_bubble = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_t = 0; m_bubble = 0;
        end else if (m_active) begin
            if (bus.abort) begin
                m_active = 0; m_t = 0; m_bubble = 0;
            end else if (m_t == TOTAL) begin
                m_active = 0; m_t = 0; m_bubble = 0;
            end else if (stall) begin
                m_bubble = 1;
            end else begin
                m_t++; m_bubble = 0;
            end
        end else if (bus.start && !bus.abort) begin
            m_active = 1; m_t = 1; m_bubble = 0;
        end
    end

    always @(negedge clk) begin
        int s, r, k, span, est;
        bit ebusy, edone, erv, efl;
        logic [AW-1:0] ea, eb;
        logic [LOG2N-2:0] etw;
        ebusy = 0; edone = 0; erv = 0; efl = 0; est = 0;
        ea = '0; eb = '0; etw = '0;
        if (m_active) begin
            ebusy = 1;
            if (m_t == TOTAL) begin
                edone = 1;
                est   = LOG2N - 1;
            end else begin
                s = (m_t - 1) / PER;
                r = (m_t - 1) % PER;
                est = s;
                if (r < HALF) begin
                    k    = r;
                    span = 1 << s;
                    ea   = AW'((k / span) * 2 * span + k % span);
                    eb   = AW'((k / span) * 2 * span + k % span + span);
                    etw  = (LOG2N-1)'((k % span) * (1 << (LOG2N - 1 - s)));
                    erv  = !m_bubble;
                end
            end
            efl = (est == 0);
        end
        chk("busy",        64'(bus.busy),        64'(ebusy));
        chk("done",        64'(bus.done),        64'(edone));
        chk("stage",       64'(bus.stage),       64'(est));
        chk("first_level", 64'(bus.first_level), 64'(efl));
        chk("rd_valid",    64'(bus.rd_valid),    64'(erv));
        chk("rd_addr_a",   64'(bus.rd_addr_a),   64'(ea));
        chk("rd_addr_b",   64'(bus.rd_addr_b),   64'(eb));
        chk("tw_addr",     64'(bus.tw_addr),     64'(etw));
    end

    int exp_a[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_b[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int got_a[12], got_b[12], got_tw[12];
    bit busy_log[64], rv_log[64], fl_log[64];
    int n_rd, n_done, done_at;

    task automatic start_pulse();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
    endtask

    // Observe cycles 1..ncyc after a start; optionally re-pulse start, abort or stall.
    task automatic watch(input int ncyc, input int restart_at, input int abort_at,
                         input int stall_from, input int stall_len);
        n_rd = 0; n_done = 0; done_at = -1;
        for (int c = 1; c <= ncyc; c++) begin
            busy_log[c] = bus.busy;
            rv_log[c]   = bus.rd_valid;
            fl_log[c]   = bus.first_level;
            if (bus.rd_valid) begin
                if (n_rd < 12) begin
                    got_a[n_rd]  = int'(bus.rd_addr_a);
                    got_b[n_rd]  = int'(bus.rd_addr_b);
                    got_tw[n_rd] = int'(bus.tw_addr);
                end
                n_rd++;
            end
            if (bus.done) begin n_done++; done_at = c; end
            bus.start = (c == restart_at);
            bus.abort = (c == abort_at);
            stall     = (c >= stall_from) && (c < stall_from + stall_len);
            @(negedge clk);
        end
        bus.start = 1'b0; bus.abort = 1'b0; stall = 1'b0;
    endtask

    task automatic chk_reads(input string tag);
        chk({tag, "_nreads"}, 64'(n_rd), 64'd12);
        for (int i = 0; i < 12; i++) begin
            chk({tag, "_a"},  64'(got_a[i]),  64'(exp_a[i]));
            chk({tag, "_b"},  64'(got_b[i]),  64'(exp_b[i]));
            chk({tag, "_tw"}, 64'(got_tw[i]), 64'(exp_tw[i]));
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy",   64'(bus.busy),     64'd0);
        chk("reset_rd_b",   64'(bus.rd_addr_b), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full transform with an ignored start at cycle 5.
        start_pulse();
        watch(TOTAL + 6, 5, -1, -1, 0);
        chk_reads("t1");
        chk("t1_first_level_c1", 64'(fl_log[1]), 64'd1);
        chk("t1_first_level_c7", 64'(fl_log[7]), 64'd0);
        chk("t1_done_cycle",     64'(done_at),   64'd19);
        chk("t1_done_count",     64'(n_done),    64'd1);
        chk("t1_idle_after",     64'(busy_log[20]), 64'd0);

        // Abort on the second read of stage 1.
        start_pulse();
        watch(TOTAL + 6, -1, 8, -1, 0);
        chk("abort_rv_before",   64'(rv_log[8]),   64'd1);
        chk("abort_rv_after",    64'(rv_log[9]),   64'd0);
        chk("abort_busy_after",  64'(busy_log[9]), 64'd0);
        chk("abort_no_done",     64'(n_done),      64'd0);
        start_pulse();
        watch(TOTAL + 4, -1, -1, -1, 0);
        chk("restart_done_cycle", 64'(done_at), 64'd19);
        chk("restart_done_count", 64'(n_done),  64'd1);

        // Asynchronous reset during stage-0 drain.
        start_pulse();
        watch(4, -1, -1, -1, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy",     64'(bus.busy),        64'd0);
        chk("rst_stage",    64'(bus.stage),       64'd0);
        chk("rst_fl",       64'(bus.first_level), 64'd0);
        chk("rst_rd_valid", 64'(bus.rd_valid),    64'd0);
        chk("rst_rd_a",     64'(bus.rd_addr_a),   64'd0);
        chk("rst_tw",       64'(bus.tw_addr),     64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        watch(TOTAL + 6, -1, -1, -1, 0);
        chk("rst_no_done", 64'(n_done),       64'd0);
        chk("rst_idle",    64'(busy_log[10]), 64'd0);

        // Simultaneous start and abort while idle.
        @(negedge clk); bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk); bus.start = 1'b0; bus.abort = 1'b0;
        chk("start_abort_idle", 64'(bus.busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("start_abort_idle_later", 64'(bus.busy), 64'd0);

`ifdef FFT_STAGE_CTRL_STALL_EN
        // Stall for three cycles while k=2 of stage 0 is presented.
        start_pulse();
        watch(TOTAL + 8, -1, -1, 3, 3);
        chk_reads("stall");
        chk("stall_bubble",     64'(rv_log[5]), 64'd0);
        chk("stall_done_cycle", 64'(done_at),   64'd22);
        chk("stall_done_count", 64'(n_done),    64'd1);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
